program_counter_stack: RTL and testbench

- Parametrised next-generation program counter for the processor datapath.
- Adds the following to plain sequential increment:
  - absolute jump
  - PC-relative branch
  - hardware call/return stack of configurable depth
- Feeds the instruction memory address.
- Takes its control strobes from the control-unit FSM, one command per cycle.

---
 rtl/program_counter_stack.sv | 63 ++++++
 tb/tb_program_counter_stack.sv | 136 +++++++++++++
 2 files changed

// File: rtl/program_counter_stack.sv
// program_counter_stack: instruction address register with jump, relative branch and call/return stack
module program_counter_stack #(
  parameter int ADDR_WIDTH = 16,
  parameter int STEP = 4,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR = 0,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  up,
  input  logic                  load,
  input  logic                  branch,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  err_clr,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DW-1:0]         depth,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_error
);
  localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_n, seq_addr;
  logic [IW-1:0] push_idx, pop_idx;
  logic do_call, do_ret, push, pop, err_set;
  assign stack_full = depth == DW'(STACK_DEPTH);
  assign stack_empty = depth == '0;
  assign seq_addr = address + ADDR_WIDTH'(STEP);
  assign push_idx = IW'(depth);
  assign pop_idx = IW'(depth - DW'(1));
  always_comb begin
    do_call = !load && !branch && call;
    do_ret = !load && !branch && !call && ret;
    push = do_call && !stack_full;
    pop = do_ret && !stack_empty;
    err_set = (do_call && stack_full) || (do_ret && stack_empty);
    addr_n = load ? target :
             branch ? address + offset :
             push ? target :
             pop ? stack[pop_idx] :
             (do_call || do_ret) ? address :
             up ? seq_addr : address;
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      address <= ADDR_WIDTH'(RESET_ADDR);
      depth <= '0;
      stack_error <= 1'b0;
    end else begin
      address <= addr_n;
      depth <= push ? depth + DW'(1) : pop ? depth - DW'(1) : depth;
      stack_error <= err_set || (stack_error && !err_clr);
    end
  end
  // entries beyond depth are never read, so the array needs no reset
  always_ff @(posedge clock) begin
    if (push) stack[push_idx] <= seq_addr;
  end
endmodule

// File: tb/tb_program_counter_stack.sv
// tb_program_counter_stack: directed vectors with hand-computed expectations
module tb_program_counter_stack;
  logic clock = 1'b0;
  logic clear, up, load, branch, call, ret, err_clr;
  logic [15:0] target, offset, address;
  logic [2:0] depth;
  logic stack_full, stack_empty, stack_error;
  int checks = 0;
  int errors = 0;

  program_counter_stack dut (
    .clock(clock), .clear(clear), .up(up), .load(load), .branch(branch),
    .call(call), .ret(ret), .err_clr(err_clr), .target(target), .offset(offset),
    .address(address), .depth(depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_error(stack_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    {up, load, branch, call, ret, err_clr} = '0;
  endtask

  task automatic do_load(input logic [15:0] t);
    load = 1'b1; target = t; cyc();
  endtask

  task automatic do_call(input logic [15:0] t);
    call = 1'b1; target = t; cyc();
  endtask

  initial begin
    clear = 1'b1;
    {up, load, branch, call, ret, err_clr} = '0;
    target = '0; offset = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_addr", address, 32'h0);
    check("rst_depth", depth, 0);
    check("rst_empty", stack_empty, 1);
    check("rst_full", stack_full, 0);
    check("rst_err", stack_error, 0);
    clear = 1'b0;
    do_call(16'h0010);
    check("pre_clr_addr", address, 32'h0010);
    check("pre_clr_depth", depth, 1);
    #2 clear = 1'b1;
    #1;
    check("async_addr", address, 32'h0);
    check("async_depth", depth, 0);
    check("async_empty", stack_empty, 1);
    #1 clear = 1'b0;
    up = 1'b1; cyc(); check("up1", address, 32'h0004);
    up = 1'b1; cyc(); check("up2", address, 32'h0008);
    up = 1'b1; cyc(); check("up3", address, 32'h000C);
    do_load(16'h0020);
    branch = 1'b1; offset = 16'hFFF8; cyc();
    check("branch_back", address, 32'h0018);
    branch = 1'b1; offset = 16'h0100; cyc();
    check("branch_fwd", address, 32'h0118);
    do_load(16'h1234);
    check("load", address, 32'h1234);
    do_load(16'hFFFC);
    up = 1'b1; cyc();
    check("wrap_addr", address, 32'h0000);
    check("wrap_err", stack_error, 0);
    up = 1'b1; cyc(); up = 1'b1; cyc(); check("hold_addr", address, 32'h0008);
    cyc(); check("idle_hold", address, 32'h0008);
    do_load(16'h0100);
    do_call(16'h0400);
    check("call_addr", address, 32'h0400);
    check("call_depth", depth, 1);
    up = 1'b1; cyc();
    check("call_up", address, 32'h0404);
    ret = 1'b1; cyc();
    check("ret_addr", address, 32'h0104);
    check("ret_depth", depth, 0);
    do_load(16'h1000);
    do_call(16'h2000);
    do_call(16'h3000);
    do_call(16'h4000);
    check("d3_full", stack_full, 0);
    do_call(16'h5000);
    check("nest_addr", address, 32'h5000);
    check("nest_depth", depth, 4);
    check("nest_full", stack_full, 1);
    check("nest_empty", stack_empty, 0);
    check("nest_err", stack_error, 0);
    do_call(16'h6000);
    check("ovf_addr", address, 32'h5000);
    check("ovf_depth", depth, 4);
    check("ovf_err", stack_error, 1);
    ret = 1'b1; cyc(); check("pop1", address, 32'h4004); check("pop1_depth", depth, 3);
    ret = 1'b1; cyc(); check("pop2", address, 32'h3004);
    ret = 1'b1; cyc(); check("pop3", address, 32'h2004);
    ret = 1'b1; cyc(); check("pop4", address, 32'h1004);
    check("pop_depth", depth, 0);
    check("pop_empty", stack_empty, 1);
    check("err_sticky", stack_error, 1);
    err_clr = 1'b1; cyc();
    check("err_clr1", stack_error, 0);
    ret = 1'b1; cyc();
    check("udf_addr", address, 32'h1004);
    check("udf_depth", depth, 0);
    check("udf_err", stack_error, 1);
    err_clr = 1'b1; cyc();
    check("err_clr2", stack_error, 0);
    err_clr = 1'b1; ret = 1'b1; cyc();
    check("set_wins", stack_error, 1);
    err_clr = 1'b1; cyc();
    check("err_clr3", stack_error, 0);
    load = 1'b1; call = 1'b1; up = 1'b1; target = 16'h0040; cyc();
    check("prio_addr", address, 32'h0040);
    check("prio_depth", depth, 0);
    branch = 1'b1; call = 1'b1; offset = 16'h0010; target = 16'h0900; cyc();
    check("prio_br_addr", address, 32'h0050);
    check("prio_br_depth", depth, 0);
    do_call(16'h0080);
    ret = 1'b1; cyc();
    check("call_ret_b2b", address, 32'h0054);
    check("b2b_depth", depth, 0);
    check("final_err", stack_error, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
